alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters (A and B, e.g. the execute stage and a multi-cycle helper unit). The block arbitrates round-robin, drives the ALU operand and command inputs from the winner, and registers the ALU result into a one-entry response buffer with a valid/ready handshake. It also flags unsupported command codes. It sits beside the ALU, and the ALU itself is instantiated outside this block.

Parameters:
WIDTH, 32, operand and result width
CMD_W, 4, ALU command width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
a_valid  in  1  requester A has an operation
a_ready  out  1  A's operation accepted this cycle
a_data1  in  WIDTH  A operand 1
a_data2  in  WIDTH  A operand 2 (shift amount for shifts)
a_cmd  in  CMD_W  A ALU command
b_valid  in  1  requester B has an operation
b_ready  out  1  B's operation accepted this cycle
b_data1  in  WIDTH  B operand 1
b_data2  in  WIDTH  B operand 2
b_cmd  in  CMD_W  B ALU command
alu_data1  out  WIDTH  to ALU data1
alu_data2  out  WIDTH  to ALU data2
alu_cmd  out  CMD_W  to ALU command
alu_result  in  WIDTH  from ALU result (combinational)
rsp_valid  out  1  response buffer holds a result
rsp_ready  in  1  consumer takes the response
rsp_id  out  1  0 = A, 1 = B
rsp_result  out  WIDTH  registered result
rsp_err  out  1  command was unsupported

Behaviour:
- Legal commands: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR, 1000 SLL, 1001 SRA, 1010 SRL. All other codes are illegal.
- State machine has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_issue is asserted when state is EMPTY, or when state is FULL and rsp_ready=1. This allows back-to-back throughput of 1 operation per cycle.
- Grant:
  - Grant is issued only when can_issue=1.
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, the requester not granted last time wins.
  - last_grant updates only on a grant.
- a_ready and b_ready are combinational and one-hot-or-zero. They mean grant this cycle. They never depend on the other requester's ready.
- ALU drive:
  - alu_data1, alu_data2 and alu_cmd are a combinational mux of the granted requester's inputs.
  - With no grant, these outputs are all zero (cmd 0000).
- Capture on grant at the clock edge:
  - rsp_id is set to the granted requester.
  - If the command is legal: rsp_result=alu_result and rsp_err=0.
  - If the command is illegal: rsp_result=0 and rsp_err=1.
  - State goes to FULL.
- Latency: an operation accepted in cycle N gives rsp_valid=1 in cycle N+1.
- State transitions:
  - FULL & rsp_ready & no grant → EMPTY.
  - FULL & rsp_ready=0 → hold. All rsp_* outputs stay stable and a_ready=b_ready=0.
  - FULL & rsp_ready & grant → stay FULL with the new contents.
- Requesters must hold valid and their operands stable until ready. The block does not latch operands before grant.
- Reset (also when asserted mid-operation, including while FULL):
  - State goes to EMPTY. rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
  - last_grant=B, so A wins the first tie.
  - Any response held in the buffer is discarded.
  - a_ready=b_ready=0 during the reset cycle.
- Width: the result is exactly WIDTH bits, and overflow wraps. Shift amounts come from data2 unmodified; the ALU defines their semantics.

Test Plan:
- After reset, A ADD 5+3, rsp_ready=1 → a_ready=1 in cycle N; cycle N+1 gives rsp_valid=1, rsp_id=0, rsp_result=8, rsp_err=0.
- A SUB 10−4 and B AND 0xF0&0x3C, both valid in the same cycle → A is granted first (result 6, id 0), B the next cycle (result 0x30, id 1), with no idle cycle between them.
- Backpressure: the buffer is FULL with 8, rsp_ready=0 for 3 cycles, and A is valid → a_ready=0 throughout and the outputs stay constant. When rsp_ready=1, A is granted in that same cycle.
- Illegal command 0011 from B → rsp_err=1, rsp_result=0, rsp_id=1. The next legal OR 0x1|0x2 gives 3 with rsp_err=0.
- B SRA 0x80000000 by 4 → 0xF8000000. B SRL with the same operands → 0x08000000.
- Reset asserted while FULL with A and B both valid → the following cycle has rsp_valid=0 and the ready signals at 0. After rst is released, A wins the first tie.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               requesters (A and B). Drives the ALU from the winner and
//               captures the result into a one-entry valid/ready response
//               buffer; unsupported commands are flagged instead of computed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data1,
    input  logic [WIDTH-1:0] a_data2,
    input  logic [CMD_W-1:0] a_cmd,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data1,
    input  logic [WIDTH-1:0] b_data2,
    input  logic [CMD_W-1:0] b_cmd,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [CMD_W-1:0] alu_cmd,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err
);

    // Supported ALU command encodings
    localparam logic [CMD_W-1:0] c_cmd_add = CMD_W'(4'b0000);
    localparam logic [CMD_W-1:0] c_cmd_sub = CMD_W'(4'b0010);
    localparam logic [CMD_W-1:0] c_cmd_and = CMD_W'(4'b0100);
    localparam logic [CMD_W-1:0] c_cmd_or  = CMD_W'(4'b0101);
    localparam logic [CMD_W-1:0] c_cmd_nor = CMD_W'(4'b0110);
    localparam logic [CMD_W-1:0] c_cmd_xor = CMD_W'(4'b0111);
    localparam logic [CMD_W-1:0] c_cmd_sll = CMD_W'(4'b1000);
    localparam logic [CMD_W-1:0] c_cmd_sra = CMD_W'(4'b1001);
    localparam logic [CMD_W-1:0] c_cmd_srl = CMD_W'(4'b1010);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;   // 0 = A granted last, 1 = B granted last
    logic             w_can_issue;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_grant;
    logic             w_cmd_legal;

    // Arbitration: a slot exists when the buffer is empty or being drained;
    // on a tie the requester that did not win last time is chosen.
    always_comb begin
        w_can_issue = !rst && ((r_state == ST_EMPTY) || rsp_ready);
        w_grant_a   = w_can_issue && a_valid && (!b_valid || r_last_grant);
        w_grant_b   = w_can_issue && b_valid && (!a_valid || !r_last_grant);
        w_grant     = w_grant_a || w_grant_b;
        a_ready     = w_grant_a;
        b_ready     = w_grant_b;
    end

    // ALU operand mux; idles at zero so the ALU sees a quiet ADD 0+0
    always_comb begin
        alu_data1 = '0;
        alu_data2 = '0;
        alu_cmd   = '0;
        if (w_grant_a) begin
            alu_data1 = a_data1;
            alu_data2 = a_data2;
            alu_cmd   = a_cmd;
        end else if (w_grant_b) begin
            alu_data1 = b_data1;
            alu_data2 = b_data2;
            alu_cmd   = b_cmd;
        end
    end

    // Decode whether the command being issued is one the ALU supports
    always_comb begin
        w_cmd_legal = 1'b0;
        case (alu_cmd)
            c_cmd_add, c_cmd_sub, c_cmd_and, c_cmd_or, c_cmd_nor,
            c_cmd_xor, c_cmd_sll, c_cmd_sra, c_cmd_srl: w_cmd_legal = 1'b1;
            default:                                    w_cmd_legal = 1'b0;
        endcase
    end

    // Next-state: a grant always (re)fills the buffer; a drain without grant empties it
    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && rsp_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // State register and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_grant <= w_grant_b;
            end
        end
    end

    // Response buffer capture on grant; contents held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else if (w_grant) begin
            rsp_id     <= w_grant_b;
            rsp_result <= w_cmd_legal ? alu_result : '0;
            rsp_err    <= !w_cmd_legal;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter, with a small
//               behavioural ALU model closing the loop on the ALU ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int CMD_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, a_ready, b_valid, b_ready;
    logic [WIDTH-1:0] a_data1, a_data2, b_data1, b_data2;
    logic [CMD_W-1:0] a_cmd, b_cmd;
    logic [WIDTH-1:0] alu_data1, alu_data2, alu_result;
    logic [CMD_W-1:0] alu_cmd;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [WIDTH-1:0] rsp_result;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.WIDTH(WIDTH), .CMD_W(CMD_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data1(a_data1), .a_data2(a_data2), .a_cmd(a_cmd),
        .b_valid(b_valid), .b_ready(b_ready), .b_data1(b_data1), .b_data2(b_data2), .b_cmd(b_cmd),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_cmd(alu_cmd), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // External ALU stand-in
    always_comb begin
        alu_result = '0;
        case (alu_cmd)
            4'b0000: alu_result = alu_data1 + alu_data2;
            4'b0010: alu_result = alu_data1 - alu_data2;
            4'b0100: alu_result = alu_data1 & alu_data2;
            4'b0101: alu_result = alu_data1 | alu_data2;
            4'b0110: alu_result = ~(alu_data1 | alu_data2);
            4'b0111: alu_result = alu_data1 ^ alu_data2;
            4'b1000: alu_result = alu_data1 << alu_data2[4:0];
            4'b1001: alu_result = $signed(alu_data1) >>> alu_data2[4:0];
            4'b1010: alu_result = alu_data1 >> alu_data2[4:0];
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2, input logic [CMD_W-1:0] c);
        a_valid = v; a_data1 = d1; a_data2 = d2; a_cmd = c;
    endtask

    task automatic drive_b(input logic v, input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2, input logic [CMD_W-1:0] c);
        b_valid = v; b_data1 = d1; b_data2 = d2; b_cmd = c;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic id, input logic [WIDTH-1:0] res, input logic err);
        check({tag, "_valid"},  {31'd0, rsp_valid}, {31'd0, v});
        check({tag, "_id"},     {31'd0, rsp_id},    {31'd0, id});
        check({tag, "_result"}, rsp_result,         res);
        check({tag, "_err"},    {31'd0, rsp_err},   {31'd0, err});
    endtask

    task automatic check_rdy(input string tag, input logic ea, input logic eb);
        check({tag, "_a_ready"}, {31'd0, a_ready}, {31'd0, ea});
        check({tag, "_b_ready"}, {31'd0, b_ready}, {31'd0, eb});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive_a(1'b1, 32'd1, 32'd1, 4'b0000);
        drive_b(1'b1, 32'd2, 32'd2, 4'b0000);
        #1;
        check_rdy("rst_hold", 1'b0, 1'b0);
        step();
        step();
        check_rsp("rst", 1'b0, 1'b0, 32'd0, 1'b0);
        check("rst_alu_cmd", {28'd0, alu_cmd}, 32'd0);
        drive_a(1'b0, 32'd0, 32'd0, 4'b0000);
        drive_b(1'b0, 32'd0, 32'd0, 4'b0000);
        rst = 1'b0;
        step();

        // A ADD 5+3
        drive_a(1'b1, 32'd5, 32'd3, 4'b0000);
        #1;
        check_rdy("add", 1'b1, 1'b0);
        check("add_alu_data1", alu_data1, 32'd5);
        step();
        drive_a(1'b0, 32'd0, 32'd0, 4'b0000);
        check_rsp("add", 1'b1, 1'b0, 32'd8, 1'b0);

        // Fresh reset so A wins the tie, then A SUB and B AND together
        do_reset();
        drive_a(1'b1, 32'd10, 32'd4, 4'b0010);
        drive_b(1'b1, 32'h0000_00F0, 32'h0000_003C, 4'b0100);
        #1;
        check_rdy("tie1", 1'b1, 1'b0);
        step();
        check_rsp("sub", 1'b1, 1'b0, 32'd6, 1'b0);
        drive_a(1'b0, 32'd0, 32'd0, 4'b0000);
        #1;
        check_rdy("tie2", 1'b0, 1'b1);
        check("and_alu_cmd", {28'd0, alu_cmd}, 32'd4);
        step();
        check_rsp("and", 1'b1, 1'b1, 32'h30, 1'b0);
        drive_b(1'b0, 32'd0, 32'd0, 4'b0000);

        // Refill with 8, then backpressure with A pending
        drive_a(1'b1, 32'd5, 32'd3, 4'b0000);
        step();
        check_rsp("fill8", 1'b1, 1'b0, 32'd8, 1'b0);
        rsp_ready = 1'b0;
        drive_a(1'b1, 32'd1, 32'd1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_rdy("bp", 1'b0, 1'b0);
            step();
            check_rsp("bp", 1'b1, 1'b0, 32'd8, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        check_rdy("bp_release", 1'b1, 1'b0);
        step();
        check_rsp("bp_add", 1'b1, 1'b0, 32'd2, 1'b0);
        drive_a(1'b0, 32'd0, 32'd0, 4'b0000);

        // Illegal command from B, then a legal OR
        drive_b(1'b1, 32'h1234, 32'h5678, 4'b0011);
        #1;
        check_rdy("ill", 1'b0, 1'b1);
        step();
        check_rsp("ill", 1'b1, 1'b1, 32'd0, 1'b1);
        drive_b(1'b1, 32'h1, 32'h2, 4'b0101);
        step();
        check_rsp("or", 1'b1, 1'b1, 32'd3, 1'b0);

        // Shifts from B
        drive_b(1'b1, 32'h8000_0000, 32'd4, 4'b1001);
        step();
        check_rsp("sra", 1'b1, 1'b1, 32'hF800_0000, 1'b0);
        drive_b(1'b1, 32'h8000_0000, 32'd4, 4'b1010);
        step();
        check_rsp("srl", 1'b1, 1'b1, 32'h0800_0000, 1'b0);

        // Drain with no request: buffer empties and ALU inputs idle at zero
        drive_b(1'b0, 32'd0, 32'd0, 4'b0000);
        #1;
        check("idle_alu_data1", alu_data1, 32'd0);
        step();
        check("drain_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset while FULL with both requesters waiting
        drive_a(1'b1, 32'd5, 32'd3, 4'b0000);
        step();
        check_rsp("prefill", 1'b1, 1'b0, 32'd8, 1'b0);
        drive_a(1'b1, 32'd7, 32'd7, 4'b0000);
        drive_b(1'b1, 32'd9, 32'd9, 4'b0000);
        rst = 1'b1;
        #1;
        check_rdy("midrst", 1'b0, 1'b0);
        step();
        check_rsp("midrst", 1'b0, 1'b0, 32'd0, 1'b0);
        check_rdy("midrst_after", 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_rdy("post_rst_tie", 1'b1, 1'b0);
        step();
        check_rsp("post_rst_a", 1'b1, 1'b0, 32'd14, 1'b0);
        drive_a(1'b0, 32'd0, 32'd0, 4'b0000);
        #1;
        check_rdy("post_rst_b", 1'b0, 1'b1);
        step();
        check_rsp("post_rst_b", 1'b1, 1'b1, 32'd18, 1'b0);
        drive_b(1'b0, 32'd0, 32'd0, 4'b0000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
